// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared definitions for the ID-stage sequencing controller and the decoder.
// Holds the SWP opcode, the SWP micro-op exec commands, the SWP operand
// select encodings and the controller state type.
package pipeline_stall_ctrl_pkg;

    localparam int unsigned OPC_W     = 6;
    localparam int unsigned REG_W     = 5;
    localparam int unsigned CMD_W     = 4;
    localparam int unsigned SWP_SEL_W = 2;

    localparam logic [OPC_W-1:0] OP_SWP = 6'b111111;

    localparam logic [CMD_W-1:0] EXEC_SWP_FIRST  = 4'b1100;
    localparam logic [CMD_W-1:0] EXEC_SWP_SECOND = 4'b1101;
    localparam logic [CMD_W-1:0] EXEC_NONE       = 4'b0000;

    localparam logic [SWP_SEL_W-1:0] SWP_SEL_NONE   = 2'b00;
    localparam logic [SWP_SEL_W-1:0] SWP_SEL_FIRST  = 2'b01;
    localparam logic [SWP_SEL_W-1:0] SWP_SEL_SECOND = 2'b10;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWP_B = 1'b1
    } state_t;

endpackage

// File: rtl/pipeline_stall_ctrl_load_use_detect.sv
// Load-use hazard comparator.
// Flags when the instruction in EX is a load writing a non-zero register that
// the instruction in ID reads (src2 only counts when ID uses two sources).
//   src1_id, src2_id : ID source registers
//   single_src_id    : ID reads src1 only
//   dest_ex          : EX destination register
//   mem_r_en_ex      : EX is a load
//   wb_en_ex         : EX writes back
//   hazard_c         : combinational hazard flag
module load_use_detect
    import pipeline_stall_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] src1_id,
    input  logic [REG_W-1:0] src2_id,
    input  logic             single_src_id,
    input  logic [REG_W-1:0] dest_ex,
    input  logic             mem_r_en_ex,
    input  logic             wb_en_ex,
    output logic             hazard_c
);

    logic src1_hit;
    logic src2_hit;

    // R0 is hardwired zero, so a load targeting it never blocks a reader.
    always_comb begin
        src1_hit = (dest_ex == src1_id);
        src2_hit = !single_src_id && (dest_ex == src2_id);
        hazard_c = mem_r_en_ex && wb_en_ex && (dest_ex != REG_W'(0))
                   && (src1_hit || src2_hit);
    end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// ID-stage sequencing controller for the 5-stage pipeline.
// Decides freeze/bubble/flush each cycle, expands SWP into FIRST/SECOND
// micro-ops and keeps a saturating count of load-use stall cycles.
//   clk, rst          : clock, async active-high reset
//   opcode_id, src*_id, single_src_id : ID instruction fields
//   dest_ex, mem_r_en_ex, wb_en_ex    : EX instruction fields
//   branch_taken      : branch resolved taken in EX
//   freeze, bubble, flush             : pipeline register controls (comb)
//   swp_sel, ovr_en, ovr_cmd          : SWP operand select / exec override (comb)
//   stall_cnt         : registered saturating load-use stall count
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [OPC_W-1:0]     opcode_id,
    input  logic [REG_W-1:0]     src1_id,
    input  logic [REG_W-1:0]     src2_id,
    input  logic                 single_src_id,
    input  logic [REG_W-1:0]     dest_ex,
    input  logic                 mem_r_en_ex,
    input  logic                 wb_en_ex,
    input  logic                 branch_taken,
    output logic                 freeze,
    output logic                 bubble,
    output logic                 flush,
    output logic [SWP_SEL_W-1:0] swp_sel,
    output logic                 ovr_en,
    output logic [CMD_W-1:0]     ovr_cmd,
    output logic [CNT_W-1:0]     stall_cnt
);

    state_t state_q;
    state_t state_d;
    logic   hazard_c;
    logic   stall_inc_c;

    load_use_detect u_load_use_detect (
        .src1_id       (src1_id),
        .src2_id       (src2_id),
        .single_src_id (single_src_id),
        .dest_ex       (dest_ex),
        .mem_r_en_ex   (mem_r_en_ex),
        .wb_en_ex      (wb_en_ex),
        .hazard_c      (hazard_c)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and outputs; branch flush > SWP second half > load-use > SWP start.
    always_comb begin
        state_d     = ST_IDLE;
        freeze      = 1'b0;
        bubble      = 1'b0;
        flush       = 1'b0;
        swp_sel     = SWP_SEL_NONE;
        ovr_en      = 1'b0;
        ovr_cmd     = EXEC_NONE;
        stall_inc_c = 1'b0;

        // Outputs are forced quiet during reset regardless of ID/EX contents.
        if (rst) begin
            state_d = ST_IDLE;
        end else if (branch_taken) begin
            flush = 1'b1;
        end else if (state_q == ST_SWP_B) begin
            // The stalled load has already left EX, so no hazard check here.
            swp_sel = SWP_SEL_SECOND;
            ovr_en  = 1'b1;
            ovr_cmd = EXEC_SWP_SECOND;
        end else if (hazard_c) begin
            // SWP recognition waits until the stall has cleared.
            freeze      = 1'b1;
            bubble      = 1'b1;
            stall_inc_c = 1'b1;
        end else if (opcode_id == OP_SWP) begin
            freeze  = 1'b1;
            swp_sel = SWP_SEL_FIRST;
            ovr_en  = 1'b1;
            ovr_cmd = EXEC_SWP_FIRST;
            state_d = ST_SWP_B;
        end
    end

    // Saturating load-use stall counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall_inc_c && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
module tb_pipeline_stall_ctrl;

    logic       clk;
    logic       rst;
    logic [5:0] opcode_id;
    logic [4:0] src1_id;
    logic [4:0] src2_id;
    logic       single_src_id;
    logic [4:0] dest_ex;
    logic       mem_r_en_ex;
    logic       wb_en_ex;
    logic       branch_taken;

    logic        freeze, bubble, flush, ovr_en;
    logic [1:0]  swp_sel;
    logic [3:0]  ovr_cmd;
    logic [15:0] stall_cnt;

    logic        s_freeze, s_bubble, s_flush, s_ovr_en;
    logic [1:0]  s_swp_sel;
    logic [3:0]  s_ovr_cmd;
    logic [3:0]  s_stall_cnt;

    int checks;
    int errors;

    // {freeze, bubble, flush, swp_sel, ovr_en, ovr_cmd}
    logic [9:0] obs;
    logic [9:0] s_obs;
    assign obs   = {freeze, bubble, flush, swp_sel, ovr_en, ovr_cmd};
    assign s_obs = {s_freeze, s_bubble, s_flush, s_swp_sel, s_ovr_en, s_ovr_cmd};

    localparam logic [9:0] V_IDLE   = 10'b0_0_0_00_0_0000;
    localparam logic [9:0] V_STALL  = 10'b1_1_0_00_0_0000;
    localparam logic [9:0] V_FLUSH  = 10'b0_0_1_00_0_0000;
    localparam logic [9:0] V_SWP1   = 10'b1_0_0_01_1_1100;
    localparam logic [9:0] V_SWP2   = 10'b0_0_0_10_1_1101;

    pipeline_stall_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .opcode_id(opcode_id), .src1_id(src1_id),
        .src2_id(src2_id), .single_src_id(single_src_id), .dest_ex(dest_ex),
        .mem_r_en_ex(mem_r_en_ex), .wb_en_ex(wb_en_ex), .branch_taken(branch_taken),
        .freeze(freeze), .bubble(bubble), .flush(flush), .swp_sel(swp_sel),
        .ovr_en(ovr_en), .ovr_cmd(ovr_cmd), .stall_cnt(stall_cnt)
    );

    pipeline_stall_ctrl #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .opcode_id(opcode_id), .src1_id(src1_id),
        .src2_id(src2_id), .single_src_id(single_src_id), .dest_ex(dest_ex),
        .mem_r_en_ex(mem_r_en_ex), .wb_en_ex(wb_en_ex), .branch_taken(branch_taken),
        .freeze(s_freeze), .bubble(s_bubble), .flush(s_flush), .swp_sel(s_swp_sel),
        .ovr_en(s_ovr_en), .ovr_cmd(s_ovr_cmd), .stall_cnt(s_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive at the falling edge, then settle before sampling.
    task automatic drive(input logic [5:0] op, input logic [4:0] s1, input logic [4:0] s2,
                         input logic single, input logic [4:0] dst, input logic ld,
                         input logic wb, input logic br);
        @(negedge clk);
        opcode_id     = op;
        src1_id       = s1;
        src2_id       = s2;
        single_src_id = single;
        dest_ex       = dst;
        mem_r_en_ex   = ld;
        wb_en_ex      = wb;
        branch_taken  = br;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(6'b111111, 5'd7, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
        checks++;
        if (obs !== V_IDLE) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected %b", obs, V_IDLE);
        end
        drive(6'b000000, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        // start a SWP, enter SWP_B, then reset mid-SWP_B
        drive(6'b111111, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        drive(6'b111111, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs !== V_SWP2) begin
            errors++;
            $display("FAIL reset_pre_swp_b: got %b expected %b", obs, V_SWP2);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (obs !== V_IDLE || stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid_swp: got %b cnt %0d expected %b cnt 0", obs, stall_cnt, V_IDLE);
        end
        drive(6'b000000, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        checks++;
        if (obs !== V_IDLE || stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_release: got %b cnt %0d expected %b cnt 0", obs, stall_cnt, V_IDLE);
        end
        drive(6'b000000, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs !== V_IDLE) begin
            errors++;
            $display("FAIL reset_no_second: got %b expected %b", obs, V_IDLE);
        end
    endtask

    task automatic test_swp();
        logic [9:0] exp_seq [3];
        exp_seq[0] = V_SWP1;
        exp_seq[1] = V_SWP2;
        exp_seq[2] = V_IDLE;
        for (int i = 0; i < 3; i++) begin
            drive((i < 2) ? 6'b111111 : 6'b000000, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
            checks++;
            if (obs !== exp_seq[i]) begin
                errors++;
                $display("FAIL swp_cycle%0d: got %b expected %b", i + 1, obs, exp_seq[i]);
            end
        end
        checks++;
        if (stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL swp_cnt: got %0d expected 0", stall_cnt);
        end
    endtask

    task automatic test_load_use();
        // ADD reading r5 via src2 behind LD r5
        drive(6'b000001, 5'd1, 5'd5, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        checks++;
        if (obs !== V_STALL || stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL lu_src2: got %b cnt %0d expected %b cnt 0", obs, stall_cnt, V_STALL);
        end
        drive(6'b000001, 5'd1, 5'd5, 1'b0, 5'd9, 1'b0, 1'b1, 1'b0);
        checks++;
        if (obs !== V_IDLE || stall_cnt !== 16'd1) begin
            errors++;
            $display("FAIL lu_after: got %b cnt %0d expected %b cnt 1", obs, stall_cnt, V_IDLE);
        end
        // single source: src2 match ignored
        drive(6'b000001, 5'd3, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
        checks++;
        if (obs !== V_IDLE) begin
            errors++;
            $display("FAIL lu_single_src: got %b expected %b", obs, V_IDLE);
        end
        // R0 never hazards
        drive(6'b000001, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (obs !== V_IDLE) begin
            errors++;
            $display("FAIL lu_r0: got %b expected %b", obs, V_IDLE);
        end
        // non-writeback load does not hazard
        drive(6'b000001, 5'd5, 5'd5, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
        checks++;
        if (obs !== V_IDLE) begin
            errors++;
            $display("FAIL lu_no_wb: got %b expected %b", obs, V_IDLE);
        end
        // single source, src1 match stalls
        drive(6'b000001, 5'd5, 5'd2, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
        checks++;
        if (obs !== V_STALL) begin
            errors++;
            $display("FAIL lu_src1: got %b expected %b", obs, V_STALL);
        end
        drive(6'b000000, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (stall_cnt !== 16'd2) begin
            errors++;
            $display("FAIL lu_cnt: got %0d expected 2", stall_cnt);
        end
    endtask

    task automatic test_branch_swp();
        drive(6'b111111, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs !== V_SWP1) begin
            errors++;
            $display("FAIL br_swp1: got %b expected %b", obs, V_SWP1);
        end
        drive(6'b111111, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (obs !== V_FLUSH) begin
            errors++;
            $display("FAIL br_in_swp_b: got %b expected %b", obs, V_FLUSH);
        end
        drive(6'b000000, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs !== V_IDLE) begin
            errors++;
            $display("FAIL br_after: got %b expected %b", obs, V_IDLE);
        end
        // branch beats a load-use hazard and does not count
        drive(6'b000001, 5'd4, 5'd2, 1'b0, 5'd4, 1'b1, 1'b1, 1'b1);
        checks++;
        if (obs !== V_FLUSH) begin
            errors++;
            $display("FAIL br_over_hazard: got %b expected %b", obs, V_FLUSH);
        end
        drive(6'b000000, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (stall_cnt !== 16'd2) begin
            errors++;
            $display("FAIL br_cnt: got %0d expected 2", stall_cnt);
        end
    endtask

    task automatic test_hazard_swp();
        drive(6'b111111, 5'd7, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
        checks++;
        if (obs !== V_STALL) begin
            errors++;
            $display("FAIL hz_swp_stall: got %b expected %b", obs, V_STALL);
        end
        drive(6'b111111, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs !== V_SWP1) begin
            errors++;
            $display("FAIL hz_swp_first: got %b expected %b", obs, V_SWP1);
        end
        drive(6'b111111, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs !== V_SWP2) begin
            errors++;
            $display("FAIL hz_swp_second: got %b expected %b", obs, V_SWP2);
        end
        drive(6'b000000, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs !== V_IDLE || stall_cnt !== 16'd3) begin
            errors++;
            $display("FAIL hz_swp_end: got %b cnt %0d expected %b cnt 3", obs, stall_cnt, V_IDLE);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] exp_seq [5];
        exp_seq[0] = V_SWP1;
        exp_seq[1] = V_SWP2;
        exp_seq[2] = V_SWP1;
        exp_seq[3] = V_SWP2;
        exp_seq[4] = V_IDLE;
        for (int i = 0; i < 5; i++) begin
            drive((i < 4) ? 6'b111111 : 6'b000000, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
            checks++;
            if (obs !== exp_seq[i]) begin
                errors++;
                $display("FAIL b2b_cycle%0d: got %b expected %b", i + 1, obs, exp_seq[i]);
            end
        end
    endtask

    task automatic test_saturation();
        drive(6'b000000, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        checks++;
        if (s_stall_cnt !== 4'd0 || stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL sat_reset: got %0d/%0d expected 0/0", s_stall_cnt, stall_cnt);
        end
        drive(6'b000000, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive(6'b000001, 5'd6, 5'd1, 1'b1, 5'd6, 1'b1, 1'b1, 1'b0);
            checks++;
            if (s_obs !== V_STALL) begin
                errors++;
                $display("FAIL sat_stall%0d: got %b expected %b", i, s_obs, V_STALL);
            end
        end
        drive(6'b000000, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (s_stall_cnt !== 4'd15) begin
            errors++;
            $display("FAIL sat_cnt4: got %0d expected 15", s_stall_cnt);
        end
        checks++;
        if (stall_cnt !== 16'd20) begin
            errors++;
            $display("FAIL sat_cnt16: got %0d expected 20", stall_cnt);
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        opcode_id     = '0;
        src1_id       = '0;
        src2_id       = '0;
        single_src_id = 1'b0;
        dest_ex       = '0;
        mem_r_en_ex   = 1'b0;
        wb_en_ex      = 1'b0;
        branch_taken  = 1'b0;

        test_reset();
        test_swp();
        test_load_use();
        test_branch_swp();
        test_hazard_swp();
        test_back_to_back();
        test_saturation();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_ctrl.md
# pipeline_stall_ctrl

Sequencing controller for the 5-stage pipeline.
- Sits beside the instruction decoder in ID and decides each cycle whether the PC and IF/ID register freeze, whether ID/EX receives a bubble, and whether IF/ID and ID/EX are flushed.
- Expands the two-step SWP instruction into its FIRST/SECOND micro-ops.
- Exports a saturating count of hazard stall cycles for performance checks.

## Interface
Parameters:
- CNT_W, 16, width of stall_cnt.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- opcode_id  in  6  opcode of instruction in ID
- src1_id  in  5  first source register in ID
- src2_id  in  5  second source register in ID
- single_src_id  in  1  ID instruction reads src1 only
- dest_ex  in  5  destination register of instruction in EX
- mem_r_en_ex  in  1  EX instruction is a load
- wb_en_ex  in  1  EX instruction writes back
- branch_taken  in  1  branch resolved taken in EX this cycle
- freeze  out  1  hold PC and IF/ID
- bubble  out  1  load NOP controls into ID/EX
- flush  out  1  clear IF/ID and ID/EX
- swp_sel  out  2  operand select for SWP: 00 none, 01 first, 10 second
- ovr_en  out  1  ovr_cmd replaces decoder exec_cmd
- ovr_cmd  out  4  exec_cmd override
- stall_cnt  out  CNT_W  saturating count of load-use stall cycles

## Operation
State machine: IDLE, SWP_B. Only the state and stall_cnt are registered; all other outputs are combinational from state and inputs.

Defaults every cycle: all outputs 0, next state IDLE.

Priority 1, branch_taken=1 (any state):
- flush=1.
- Next state IDLE; an in-progress SWP is aborted.
- No freeze, no bubble, stall_cnt unchanged.

Priority 2, state SWP_B:
- swp_sel=10, ovr_en=1, ovr_cmd=1101.
- freeze=0; next IDLE.
- Load-use check is ignored, because the load has already left EX.

Priority 3, state IDLE with load-use hazard:
- Hazard condition: mem_r_en_ex & wb_en_ex & dest_ex!=0 & (dest_ex==src1_id | (!single_src_id & dest_ex==src2_id)).
- Response: freeze=1, bubble=1, and stall_cnt increments.
- SWP detection is deferred to the next cycle.

Priority 4, state IDLE with opcode_id=111111 (SWP):
- freeze=1, swp_sel=01, ovr_en=1, ovr_cmd=1100.
- Next state SWP_B.

Otherwise the block is transparent: all outputs 0.

Additional rules:
- R0 is hardwired zero and never creates a hazard.
- stall_cnt holds at all-ones (saturates) and never wraps.

## Timing
- Reset values: state=IDLE, stall_cnt=0. Every combinational output is 0 while rst is asserted, including freeze, bubble, flush, swp_sel=00, ovr_en=0 and ovr_cmd=0000.
- Output latency is zero cycles: outputs respond in the same cycle as their inputs.
- State and counter update on the rising clk edge.
- SWP occupies exactly 2 cycles in ID, with freeze high in the first only.
- A load-use stall lasts exactly 1 cycle per load, because the load advances out of EX the next edge.
- Back-to-back SWPs: IDLE→SWP_B→IDLE→SWP_B, with no idle gap between them.
- Reset asserted mid-SWP: state returns to IDLE immediately (asynchronous); no SECOND micro-op is issued after deassertion.
- branch_taken in the SWP_B cycle: flush wins and ovr_en=0.

## Structure
Shared package holds:
- OP_SWP=6'b111111.
- EXEC_SWP_FIRST=4'b1100 and EXEC_SWP_SECOND=4'b1101.
- SWP_SEL_NONE/FIRST/SECOND.
- The two-value state typedef.

The decoder and this block both import the package.

One natural sub-module: load_use_detect, a pure comparator producing the hazard bit from the EX/ID fields above.

## Test plan
- Reset: assert rst mid-SWP_B, release, opcode_id=000000 → all outputs 0, stall_cnt=0, no 1101 issued.
- SWP alone: opcode_id=111111 for two cycles → cycle 1: freeze=1, swp_sel=01, ovr_cmd=1100; cycle 2: freeze=0, swp_sel=10, ovr_cmd=1101; cycle 3: idle.
- Load-use: EX LD with dest_ex=5; ID ADD src2_id=5, single_src_id=0 → freeze=1, bubble=1 for one cycle, stall_cnt 0→1. Same case with single_src_id=1 and src1_id=3 → no stall. dest_ex=0 → no stall.
- Branch during SWP: SWP cycle 1, then branch_taken=1 in cycle 2 → flush=1, swp_sel=00, ovr_en=0, next cycle IDLE.
- Hazard then SWP: EX LD dest_ex=7, ID SWP src1_id=7 → cycle 1: stall only (swp_sel=00); cycles 2–3: normal SWP sequence.
- Saturation: CNT_W=4 with 20 consecutive load-use stalls → stall_cnt stops at 15.
